mc_ctrl: RTL and testbench

- Multi-cycle control sequencer for the MIPS datapath (PC, NPC, IM, GRF, EXT, ALU, DM).
- Replaces the single-cycle combinational controller. Drives an existing external IR register and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Handshakes with instruction and data memories that may take multiple cycles.
- Commits PC exactly once per instruction and counts retired instructions.

---
 rtl/mc_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mc_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer for the MIPS datapath: steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB with memory ready handshakes and a timeout.
module mc_ctrl #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic        mem_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  reg_src,
  output logic        alu_src,
  output logic [2:0]  alu_ctrl,
  output logic        ext_op,
  output logic [2:0]  npc_sel,
  output logic        instr_done,
  output logic [31:0] instr_cnt,
  output logic        err,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     cur;
  logic [7:0] wait_cnt;
  logic       is_rtype, is_add, is_sub, is_jr, is_ori, is_lui;
  logic       is_lw, is_sw, is_beq, is_jal, is_nop;
  logic       unused_zero;

  // The branch condition is resolved by the NPC, not by the sequencer.
  assign unused_zero = zero;

  assign is_rtype = (opcode == 6'h00);
  assign is_add   = is_rtype && (funct == 6'h20);
  assign is_sub   = is_rtype && (funct == 6'h22);
  assign is_jr    = is_rtype && (funct == 6'h08);
  assign is_ori   = (opcode == 6'h0D);
  assign is_lui   = (opcode == 6'h0F);
  assign is_lw    = (opcode == 6'h23);
  assign is_sw    = (opcode == 6'h2B);
  assign is_beq   = (opcode == 6'h04);
  assign is_jal   = (opcode == 6'h03);
  assign is_nop   = !(is_add | is_sub | is_jr | is_ori | is_lui |
                      is_lw | is_sw | is_beq | is_jal);

  assign state      = cur;
  assign instr_done = pc_we;

  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    reg_dst  = 2'd0;
    reg_src  = 2'd0;
    alu_src  = 1'b0;
    alu_ctrl = 3'd0;
    ext_op   = 1'b0;
    npc_sel  = 3'd0;
    if (!reset) begin
      // ALU setup is held through MEM and WB so address and result stay stable.
      if (cur == S_EXEC || cur == S_MEM || cur == S_WB) begin
        alu_src  = is_ori | is_lui | is_lw | is_sw;
        alu_ctrl = (is_sub | is_beq) ? 3'd1 :
                   is_ori            ? 3'd2 :
                   is_lui            ? 3'd3 : 3'd0;
        ext_op   = is_lw | is_sw | is_beq;
      end
      case (cur)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        S_DECODE: begin
          if (is_jr) begin
            pc_we   = 1'b1;
            npc_sel = 3'd3;
          end else if (is_nop) begin
            pc_we   = 1'b1;
          end
        end
        S_EXEC: begin
          if (is_beq) begin
            pc_we   = 1'b1;
            npc_sel = 3'd1;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          if (dmem_ready && is_sw) begin
            mem_we = 1'b1;
            pc_we  = 1'b1;
          end
        end
        S_WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          if (is_jal) begin
            reg_dst = 2'd2;
            reg_src = 2'd2;
            npc_sel = 3'd2;
          end else if (is_lw) begin
            reg_src = 2'd1;
          end else if (is_rtype) begin
            reg_dst = 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur       <= S_FETCH;
      wait_cnt  <= 8'd0;
      instr_cnt <= 32'd0;
      err       <= 1'b0;
    end else begin
      if (pc_we) instr_cnt <= instr_cnt + 32'd1;
      case (cur)
        S_FETCH: begin
          if (imem_ready) begin
            cur      <= S_DECODE;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == WAIT_LAST) begin
            cur <= S_HALT;
            err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          wait_cnt <= 8'd0;
          if (is_jr || is_nop) cur <= S_FETCH;
          else if (is_jal)     cur <= S_WB;
          else                 cur <= S_EXEC;
        end
        S_EXEC: begin
          wait_cnt <= 8'd0;
          if (is_beq)             cur <= S_FETCH;
          else if (is_lw || is_sw) cur <= S_MEM;
          else                    cur <= S_WB;
        end
        S_MEM: begin
          if (dmem_ready) begin
            wait_cnt <= 8'd0;
            cur      <= is_sw ? S_FETCH : S_WB;
          end else if (wait_cnt == WAIT_LAST) begin
            cur <= S_HALT;
            err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_WB: begin
          wait_cnt <= 8'd0;
          cur      <= S_FETCH;
        end
        S_HALT: cur <= S_HALT;
        default: cur <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-cycle comparison against a phase-route reference model,
// a latency/decode table, hand-written corner sequences and randomized traffic.
module tb_mc_ctrl;
  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero, imem_ready, dmem_ready;
  logic        imem_req, dmem_req, ir_we, pc_we, reg_we, mem_we;
  logic [1:0]  reg_dst, reg_src;
  logic        alu_src;
  logic [2:0]  alu_ctrl;
  logic        ext_op;
  logic [2:0]  npc_sel;
  logic        instr_done;
  logic [31:0] instr_cnt;
  logic        err;
  logic [2:0]  state;

  always #5 clk = ~clk;

  mc_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
    .mem_we(mem_we), .reg_dst(reg_dst), .reg_src(reg_src), .alu_src(alu_src),
    .alu_ctrl(alu_ctrl), .ext_op(ext_op), .npc_sel(npc_sel),
    .instr_done(instr_done), .instr_cnt(instr_cnt), .err(err), .state(state)
  );

  typedef enum int {C_ADD, C_SUB, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_JAL, C_NOP} cls_t;
  typedef int q_t[$];
  typedef struct packed {
    logic [2:0] st;
    logic       imem_req, dmem_req, ir_we, pc_we, reg_we, mem_we, done, err;
    logic [1:0] dst, src;
    logic       asrc;
    logic [2:0] actl;
    logic       ext;
    logic [2:0] npc;
  } obs_t;

  int passed = 0;
  int total  = 0;

  // Reference model: current phase code, remaining phases of the instruction.
  int          m_ph;
  q_t          m_route;
  cls_t        m_cls;
  cls_t        cur_cls;
  int          m_wait;
  logic        m_err;
  logic [31:0] m_cnt;

  // Observations for the instruction in flight.
  logic        done_seen;
  int          npc_at_commit, reg_we_n, mem_we_n, memwe_alone, strobe_n;
  int          dst_at_we, src_at_we;

  function automatic q_t route(cls_t c);
    q_t r;
    case (c)
      C_ADD, C_SUB, C_ORI, C_LUI: r = {1, 2, 4};
      C_LW:                       r = {1, 2, 3, 4};
      C_SW:                       r = {1, 2, 3};
      C_BEQ:                      r = {1, 2};
      C_JAL:                      r = {1, 4};
      default:                    r = {1};
    endcase
    return r;
  endfunction

  function automatic void enc(cls_t c, output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom);
    case (c)
      C_ADD: begin op = 6'h00; fn = 6'h20; end
      C_SUB: begin op = 6'h00; fn = 6'h22; end
      C_JR:  begin op = 6'h00; fn = 6'h08; end
      C_ORI: op = 6'h0D;
      C_LUI: op = 6'h0F;
      C_LW:  op = 6'h23;
      C_SW:  op = 6'h2B;
      C_BEQ: op = 6'h04;
      C_JAL: op = 6'h03;
      default: begin
        case ($urandom_range(2, 0))
          0:       begin op = 6'h00; fn = 6'h21; end
          1:       op = 6'h02;
          default: op = 6'h3F;
        endcase
      end
    endcase
  endfunction

  function automatic void expect_out(output obs_t e, output obs_t m);
    logic commit;
    e = '0;
    m = '0;
    m.st = '1; m.err = '1;
    m.imem_req = 1'b1; m.dmem_req = 1'b1; m.ir_we = 1'b1; m.pc_we = 1'b1;
    m.reg_we = 1'b1; m.mem_we = 1'b1; m.done = 1'b1;
    e.st  = 3'(m_ph);
    e.err = m_err;
    if (reset || m_ph == 7) return;
    e.imem_req = (m_ph == 0);
    e.ir_we    = (m_ph == 0) && imem_ready;
    e.dmem_req = (m_ph == 3);
    commit     = (m_ph != 0) && (m_route.size() == 0) && (m_ph != 3 || dmem_ready);
    e.pc_we    = commit;
    e.done     = commit;
    e.mem_we   = (m_ph == 3) && (m_cls == C_SW) && dmem_ready;
    e.reg_we   = (m_ph == 4);
    if (commit) begin
      m.npc = '1;
      e.npc = (m_cls == C_BEQ) ? 3'd1 : (m_cls == C_JAL) ? 3'd2 : (m_cls == C_JR) ? 3'd3 : 3'd0;
    end
    if (m_ph == 4) begin
      m.dst = '1; m.src = '1;
      case (m_cls)
        C_JAL:        begin e.dst = 2'd2; e.src = 2'd2; end
        C_LW:         e.src = 2'd1;
        C_ADD, C_SUB: e.dst = 2'd1;
        default: ;
      endcase
    end
    if (m_ph == 2 || m_ph == 3) begin
      m.asrc = 1'b1; m.actl = '1;
      case (m_cls)
        C_SUB:       e.actl = 3'd1;
        C_ORI:       begin e.asrc = 1'b1; e.actl = 3'd2; m.ext = 1'b1; end
        C_LUI:       begin e.asrc = 1'b1; e.actl = 3'd3; end
        C_LW, C_SW:  begin e.asrc = 1'b1; m.ext = 1'b1; e.ext = 1'b1; end
        C_BEQ:       begin e.actl = 3'd1; m.ext = 1'b1; e.ext = 1'b1; end
        default: ;
      endcase
    end
  endfunction

  function automatic void model_step();
    logic rdy;
    if (reset) begin
      m_ph = 0; m_route = {}; m_wait = 0; m_err = 1'b0; m_cnt = 32'd0;
      return;
    end
    if (m_ph == 7) return;
    if (m_ph == 0 || m_ph == 3) begin
      rdy = (m_ph == 0) ? imem_ready : dmem_ready;
      if (!rdy) begin
        m_wait++;
        if (m_wait == MAX_WAIT) begin m_ph = 7; m_err = 1'b1; end
        return;
      end
      m_wait = 0;
      if (m_ph == 0) begin m_cls = cur_cls; m_route = route(cur_cls); end
    end
    if (m_route.size() == 0) begin m_cnt = m_cnt + 32'd1; m_ph = 0; end
    else m_ph = m_route.pop_front();
  endfunction

  task automatic check_cycle();
    obs_t o, e, m;
    o.st = state; o.imem_req = imem_req; o.dmem_req = dmem_req; o.ir_we = ir_we;
    o.pc_we = pc_we; o.reg_we = reg_we; o.mem_we = mem_we; o.done = instr_done;
    o.err = err; o.dst = reg_dst; o.src = reg_src; o.asrc = alu_src;
    o.actl = alu_ctrl; o.ext = ext_op; o.npc = npc_sel;
    expect_out(e, m);
    total++;
    if ((((o ^ e) & m) === '0) && (instr_cnt === m_cnt)) passed++;
    else $display("FAIL cycle @%0t got=%06h cnt=%0d required=%06h cnt=%0d care=%06h",
                  $time, o, instr_cnt, e, m_cnt, m);
    if (instr_done) done_seen = 1'b1;
    if (pc_we) npc_at_commit = int'(npc_sel);
    if (reg_we) begin reg_we_n++; dst_at_we = int'(reg_dst); src_at_we = int'(reg_src); end
    if (mem_we) mem_we_n++;
    if (mem_we && !pc_we) memwe_alone++;
    if (imem_req | dmem_req | ir_we | pc_we | reg_we | mem_we | instr_done) strobe_n++;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, int got, int req);
    total++;
    if (got == req) passed++;
    else $display("FAIL %s got=%0d required=%0d", name, got, req);
  endtask

  task automatic clear_obs();
    done_seen = 1'b0; npc_at_commit = -1; reg_we_n = 0; mem_we_n = 0;
    memwe_alone = 0; strobe_n = 0; dst_at_we = -1; src_at_we = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic run_instr(cls_t c, int iw, int dw, output int cycles);
    int fi = 0;
    int mi = 0;
    cur_cls = c;
    clear_obs();
    cycles = 0;
    while (!done_seen && m_ph != 7 && cycles < 200) begin
      if (m_ph == 0) begin
        imem_ready = (fi >= iw); fi++;
        opcode = 6'($urandom); funct = 6'($urandom);
      end else begin
        enc(c, opcode, funct);
        imem_ready = 1'($urandom);
      end
      if (m_ph == 3) begin dmem_ready = (mi >= dw); mi++; end
      else dmem_ready = 1'($urandom);
      zero = 1'($urandom);
      tick();
      cycles++;
    end
    if (cycles >= 200) begin
      total++;
      $display("FAIL run_budget got=%0d cycles required=commit or halt", cycles);
    end
  endtask

  typedef struct {
    cls_t c;
    int   lat;
    int   npc;
    int   wes;
    int   dst;
    int   src;
  } vec_t;

  initial begin
    vec_t vt[10];
    int   cyc, sum;

    vt[0] = '{C_ADD, 4, 0, 1, 1, 0};
    vt[1] = '{C_SUB, 4, 0, 1, 1, 0};
    vt[2] = '{C_ORI, 4, 0, 1, 0, 0};
    vt[3] = '{C_LUI, 4, 0, 1, 0, 0};
    vt[4] = '{C_LW,  5, 0, 1, 0, 1};
    vt[5] = '{C_SW,  4, 0, 0, 0, 0};
    vt[6] = '{C_BEQ, 3, 1, 0, 0, 0};
    vt[7] = '{C_JAL, 3, 2, 1, 2, 2};
    vt[8] = '{C_JR,  2, 3, 0, 0, 0};
    vt[9] = '{C_NOP, 2, 0, 0, 0, 0};

    reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; cur_cls = C_NOP; m_cls = C_NOP;
    m_ph = 0; m_route = {}; m_wait = 0; m_err = 1'b0; m_cnt = 32'd0;
    clear_obs();
    @(posedge clk);
    #1;

    // Reset state, with both ready inputs high during the reset cycle.
    clear_obs();
    do_reset();
    chk("reset_strobes", strobe_n, 0);
    chk("reset_state", int'(state), 0);
    chk("reset_cnt", int'(instr_cnt), 0);
    chk("reset_err", int'(err), 0);

    // Zero-wait latency and decode table.
    for (int i = 0; i < 10; i++) begin
      run_instr(vt[i].c, 0, 0, cyc);
      chk($sformatf("lat_%s", vt[i].c.name()), cyc, vt[i].lat);
      chk($sformatf("npc_%s", vt[i].c.name()), npc_at_commit, vt[i].npc);
      chk($sformatf("regwe_%s", vt[i].c.name()), reg_we_n, vt[i].wes);
      if (vt[i].wes != 0) begin
        chk($sformatf("dst_%s", vt[i].c.name()), dst_at_we, vt[i].dst);
        chk($sformatf("src_%s", vt[i].c.name()), src_at_we, vt[i].src);
      end
    end
    chk("table_cnt", int'(instr_cnt), 10);

    // lw with a slow data memory.
    run_instr(C_LW, 0, 3, cyc);
    chk("lw_wait_cycles", cyc, 8);
    chk("lw_wait_src", src_at_we, 1);
    chk("lw_wait_err", int'(err), 0);

    // sw: single write strobe, coincident with the commit.
    run_instr(C_SW, 1, 2, cyc);
    chk("sw_memwe_count", mem_we_n, 1);
    chk("sw_memwe_alone", memwe_alone, 0);
    chk("sw_regwe", reg_we_n, 0);
    chk("sw_cycles", cyc, 7);

    // beq, jal, jr back to back.
    do_reset();
    sum = 0;
    run_instr(C_BEQ, 0, 0, cyc); sum += cyc; chk("beq_npc", npc_at_commit, 1);
    run_instr(C_JAL, 0, 0, cyc); sum += cyc; chk("jal_npc", npc_at_commit, 2);
    chk("jal_dst", dst_at_we, 2);
    chk("jal_src", src_at_we, 2);
    run_instr(C_JR, 0, 0, cyc);  sum += cyc; chk("jr_npc", npc_at_commit, 3);
    chk("branch_seq_cycles", sum, 8);
    chk("branch_seq_cnt", int'(instr_cnt), 3);

    // Fetch timeout into HALT; HALT ignores ready until reset.
    do_reset();
    run_instr(C_ADD, 1000, 0, cyc);
    chk("timeout_cycles", cyc, MAX_WAIT);
    chk("timeout_state", int'(state), 7);
    chk("timeout_err", int'(err), 1);
    clear_obs();
    for (int i = 0; i < 4; i++) begin
      imem_ready = 1'b1; dmem_ready = 1'b1; enc(C_SW, opcode, funct);
      tick();
    end
    chk("halt_strobes", strobe_n, 0);
    chk("halt_state", int'(state), 7);
    do_reset();
    chk("halt_reset_state", int'(state), 0);
    chk("halt_reset_err", int'(err), 0);

    // Reset during MEM of sw with dmem_ready high aborts the store.
    cur_cls = C_SW;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    opcode = 6'($urandom); funct = 6'($urandom);
    tick();
    enc(C_SW, opcode, funct);
    tick();
    tick();
    chk("abort_in_mem", int'(state), 3);
    clear_obs();
    reset = 1'b1; dmem_ready = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_memwe", mem_we_n, 0);
    chk("abort_cnt", int'(instr_cnt), 0);
    chk("abort_state", int'(state), 0);

    // Randomized traffic against the model, with occasional timeouts.
    for (int n = 0; n < 250; n++) begin
      cls_t c;
      int   iw, dw;
      c  = cls_t'($urandom_range(9, 0));
      iw = ($urandom_range(39, 0) == 0) ? 20 : int'($urandom_range(3, 0));
      dw = ($urandom_range(29, 0) == 0) ? 20 : int'($urandom_range(4, 0));
      run_instr(c, iw, dw, cyc);
      if (m_ph == 7 || cyc >= 200) begin
        tick();
        do_reset();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
